// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_op_t    : {store, funct3} operation encoding seen on i_op
//   lsu_state_t : LSU control FSM states
//   BYTE_LANES  : byte lanes per data word
package mem_lsu_pkg;

  localparam int unsigned LSU_DATA_SIZE = 32;
  localparam int unsigned BYTE_LANES    = LSU_DATA_SIZE / 8;

  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } lsu_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StRmwRdReq,
    StRmwRdWait,
    StRmwWrReq,
    StDone,
    StFault
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu_format.sv
// Combinational datapath helpers for the load/store unit.
//   chk_op_i/chk_addr_i -> misaligned_o : alignment and encoding check for a new op
//   op_i/addr_i/word_i  -> load_data_o  : byte/halfword extract with sign/zero extend
//   op_i/addr_i/word_i/wdata_i -> merged_o : sub-word store merged into the old word
module mem_lsu_format
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  chk_op_i,
  input  logic [1:0]  chk_addr_i,
  output logic        misaligned_o,
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Unknown encodings are reported as faults so they never reach the cache.
  always_comb begin
    misaligned_o = 1'b1;
    case (chk_op_i)
      LB, LBU, SB: misaligned_o = 1'b0;
      LH, LHU, SH: misaligned_o = chk_addr_i[0];
      LW, SW:      misaligned_o = |chk_addr_i;
      default:     misaligned_o = 1'b1;
    endcase
  end

  assign byte_sel = word_i[{addr_i, 3'b000} +: 8];
  assign half_sel = word_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = word_i;
    case (op_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data_o = {24'h000000, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data_o = {16'h0000, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  // SB writes wdata[7:0] into one lane; SH writes wdata[15:0] into a lane pair.
  always_comb begin
    merged_o = word_i;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      if (op_i == SB) begin
        if (addr_i == i[1:0]) merged_o[8*i +: 8] = wdata_i[7:0];
      end else if (op_i == SH) begin
        if (addr_i[1] == i[1]) merged_o[8*i +: 8] = wdata_i[8*(i%2) +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the execute pipeline and the data cache controller.
// Accepts one op at a time (i_valid && o_ready), issues at most one outstanding
// cache request, performs read-modify-write for SB/SH, and signals completion
// with a one-cycle o_valid pulse carrying o_rdata/o_rd/o_misaligned.
//   Pipeline side : i_valid, o_ready, i_addr, i_wdata, i_op, i_rd,
//                   o_valid, o_rdata, o_rd, o_misaligned
//   Cache side    : o_req, o_req_write, o_addr, o_store_data, i_req_ready,
//                   i_data_valid, i_data
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_areset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [3:0]           i_op,
  input  logic [4:0]           i_rd,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic [4:0]           o_rd,
  output logic                 o_misaligned,
  output logic                 o_req,
  output logic                 o_req_write,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [DATA_SIZE-1:0] o_store_data,
  input  logic                 i_req_ready,
  input  logic                 i_data_valid,
  input  logic [DATA_SIZE-1:0] i_data
);

  lsu_state_t           state_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [3:0]           op_q;
  logic [4:0]           rd_q;
  // Holds store data; overwritten by the merged word during read-modify-write.
  logic [DATA_SIZE-1:0] store_q;
  logic [DATA_SIZE-1:0] rdata_q;

  logic                 new_misaligned;
  logic [DATA_SIZE-1:0] fmt_load;
  logic [DATA_SIZE-1:0] fmt_merged;

  mem_lsu_format u_format (
    .chk_op_i     (i_op),
    .chk_addr_i   (i_addr[1:0]),
    .misaligned_o (new_misaligned),
    .op_i         (op_q),
    .addr_i       (addr_q[1:0]),
    .word_i       (i_data),
    .wdata_i      (store_q),
    .load_data_o  (fmt_load),
    .merged_o     (fmt_merged)
  );

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      store_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            addr_q  <= i_addr;
            op_q    <= i_op;
            rd_q    <= i_rd;
            store_q <= i_wdata;
            if (new_misaligned) begin
              rdata_q <= '0;
              state_q <= StFault;
            end else if (i_op == SB || i_op == SH) begin
              state_q <= StRmwRdReq;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          if (i_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (i_data_valid) begin
            rdata_q <= op_q[3] ? '0 : fmt_load;
            state_q <= StDone;
          end
        end
        StRmwRdReq: begin
          if (i_req_ready) state_q <= StRmwRdWait;
        end
        StRmwRdWait: begin
          if (i_data_valid) begin
            store_q <= fmt_merged;
            state_q <= StRmwWrReq;
          end
        end
        StRmwWrReq: begin
          if (i_req_ready) state_q <= StWait;
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // All handshake outputs decode directly from the state register.
  always_comb begin
    o_ready      = (state_q == StIdle);
    o_req        = (state_q == StReq) || (state_q == StRmwRdReq) || (state_q == StRmwWrReq);
    o_req_write  = ((state_q == StReq) && op_q[3]) || (state_q == StRmwWrReq);
    o_addr       = {addr_q[ADDR_SIZE-1:2], 2'b00};
    o_store_data = o_req_write ? store_q : '0;
    o_valid      = (state_q == StDone) || (state_q == StFault);
    o_misaligned = (state_q == StFault);
    o_rdata      = rdata_q;
    o_rd         = rd_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        i_clk = 1'b0;
  logic        i_areset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_op;
  logic [4:0]  i_rd;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic [4:0]  o_rd;
  logic        o_misaligned;
  logic        o_req;
  logic        o_req_write;
  logic [31:0] o_addr;
  logic [31:0] o_store_data;
  logic        i_req_ready;
  logic        i_data_valid;
  logic [31:0] i_data;

  int n_vec = 0;
  int n_bad = 0;

  // Word-addressed backing store seen by the modelled cache.
  logic [31:0] mem [logic [29:0]];

  mem_lsu #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .i_clk        (i_clk),
    .i_areset     (i_areset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_op         (i_op),
    .i_rd         (i_rd),
    .o_valid      (o_valid),
    .o_rdata      (o_rdata),
    .o_rd         (o_rd),
    .o_misaligned (o_misaligned),
    .o_req        (o_req),
    .o_req_write  (o_req_write),
    .o_addr       (o_addr),
    .o_store_data (o_store_data),
    .i_req_ready  (i_req_ready),
    .i_data_valid (i_data_valid),
    .i_data       (i_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  // Reference rules: {store, funct3}; halfword needs even address, word needs /4.
  function automatic bit fault_of(input logic [3:0] op, input logic [31:0] a);
    int f3;
    f3 = int'(op[2:0]);
    if (op[3]) begin
      if (f3 > 2) return 1'b1;
    end else if (f3 == 3 || f3 > 5) begin
      return 1'b1;
    end
    if (f3 == 1 || f3 == 5) return (a % 2) != 0;
    if (f3 == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_of(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op[2:0])
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_of(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (op[2:0] == 3'd0) begin
      sh   = 8 * int'(a % 4);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end
    sh   = 16 * int'((a / 2) % 2);
    mask = 32'hFFFF << sh;
    return (w & ~mask) | ((wd & 32'hFFFF) << sh);
  endfunction

  // Drives one op through the DUT while acting as the cache; checks every
  // request, the completion pulse, its latency and the post-completion state.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int stall, input string nm);
    bit          exp_wr[$];
    logic [31:0] exp_data[$];
    bit          flt;
    int          lat;
    int          k;
    int          ridx;
    int          stall_left;
    bit          done;
    bit          resp;
    bit          resp_wr;
    logic [31:0] resp_data;
    logic [31:0] exp_rd;
    logic [31:0] old;

    flt    = fault_of(op, a);
    old    = mem_rd(a);
    exp_rd = 32'h0;
    if (flt) begin
      lat = 1;
    end else if (!op[3]) begin
      lat = 3;
      exp_wr.push_back(1'b0); exp_data.push_back(32'h0);
      exp_rd = load_of(op, a, old);
    end else if (op[2:0] == 3'd2) begin
      lat = 3;
      exp_wr.push_back(1'b1); exp_data.push_back(wd);
    end else begin
      lat = 5;
      exp_wr.push_back(1'b0); exp_data.push_back(32'h0);
      exp_wr.push_back(1'b1); exp_data.push_back(merge_of(op, a, old, wd));
    end
    lat += stall * exp_wr.size();

    @(negedge i_clk);
    check({nm, " ready"}, {31'h0, o_ready}, 32'h1);
    i_valid      = 1'b1;
    i_op         = op;
    i_addr       = a;
    i_wdata      = wd;
    i_rd         = rd;
    i_req_ready  = 1'b0;
    i_data_valid = 1'b0;

    k = 0; ridx = 0; stall_left = stall; done = 0; resp = 0; resp_wr = 0; resp_data = 0;
    while (!done && k < 64) begin
      @(negedge i_clk);
      k++;
      i_valid      = 1'b0;
      i_data_valid = 1'b0;
      i_req_ready  = 1'b0;
      if (o_valid) begin
        check({nm, " latency"}, k, lat);
        check({nm, " misaligned"}, {31'h0, o_misaligned}, {31'h0, flt});
        check({nm, " rdata"}, o_rdata, exp_rd);
        check({nm, " rd"}, {27'h0, o_rd}, {27'h0, rd});
        check({nm, " req count"}, ridx, exp_wr.size());
        done = 1;
      end
      if (resp) begin
        check({nm, " req low in wait"}, {31'h0, o_req}, 32'h0);
        i_data_valid = 1'b1;
        if (resp_wr) begin
          mem[a[31:2]] = resp_data;
          i_data = resp_data;
        end else begin
          i_data = mem_rd(a);
        end
        resp = 0;
      end else if (o_req) begin
        if (ridx >= exp_wr.size()) begin
          check({nm, " unexpected req"}, {31'h0, o_req}, 32'h0);
        end else begin
          check({nm, " req addr"}, o_addr, {a[31:2], 2'b00});
          check({nm, " req write"}, {31'h0, o_req_write}, {31'h0, exp_wr[ridx]});
          if (exp_wr[ridx]) check({nm, " store data"}, o_store_data, exp_data[ridx]);
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            i_req_ready = 1'b1;
            resp        = 1;
            resp_wr     = exp_wr[ridx];
            resp_data   = exp_data[ridx];
            ridx++;
            stall_left  = stall;
          end
        end
        // A response strobe while a request is pending must be ignored.
        if ($urandom_range(0, 3) == 0) begin
          i_data_valid = 1'b1;
          i_data       = $urandom;
        end
      end else begin
        i_req_ready = 1'($urandom_range(0, 1));
      end
      // A busy LSU must not consume a new op.
      if (!o_ready && !done && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b1;
        i_op    = 4'($urandom_range(0, 15));
        i_addr  = $urandom;
      end
    end
    if (!done) check({nm, " timeout"}, 32'h0, 32'h1);

    @(negedge i_clk);
    i_valid = 1'b0; i_data_valid = 1'b0; i_req_ready = 1'b0;
    check({nm, " ready after"}, {31'h0, o_ready}, 32'h1);
    check({nm, " valid pulse"}, {31'h0, o_valid}, 32'h0);
    check({nm, " rdata held"}, o_rdata, exp_rd);
  endtask

  initial begin
    i_areset = 1'b1; i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_op = '0; i_rd = '0;
    i_req_ready = 1'b0; i_data_valid = 1'b0; i_data = '0;
    #1;
    check("reset ready", {31'h0, o_ready}, 32'h1);
    check("reset valid", {31'h0, o_valid}, 32'h0);
    check("reset req", {31'h0, o_req}, 32'h0);
    check("reset req_write", {31'h0, o_req_write}, 32'h0);
    check("reset addr", o_addr, 32'h0);
    check("reset store_data", o_store_data, 32'h0);
    check("reset rdata", o_rdata, 32'h0);
    check("reset rd", {27'h0, o_rd}, 32'h0);
    check("reset misaligned", {31'h0, o_misaligned}, 32'h0);
    repeat (2) @(negedge i_clk);
    i_areset = 1'b0;

    mem[30'h40] = 32'hDEAD_BEEF;
    run_op(4'b0010, 32'h0000_0100, 32'h0, 5'd7, 0, "lw 100");
    mem[30'h40] = 32'h80FF_1234;
    run_op(4'b0000, 32'h0000_0103, 32'h0, 5'd1, 0, "lb 103");
    run_op(4'b0100, 32'h0000_0103, 32'h0, 5'd2, 0, "lbu 103");
    run_op(4'b0101, 32'h0000_0102, 32'h0, 5'd3, 0, "lhu 102");
    mem[30'h80] = 32'h1122_3344;
    run_op(4'b1000, 32'h0000_0201, 32'hAA, 5'd4, 0, "sb 201");
    check("sb merged word", mem[30'h80], 32'h1122_AA44);
    run_op(4'b1010, 32'h0000_0300, 32'hCAFE_F00D, 5'd5, 4, "sw 300 stall");
    run_op(4'b0010, 32'h0000_0102, 32'h0, 5'd6, 0, "lw 102 fault");
    run_op(4'b0010, 32'hFFFF_FFFC, 32'h0, 5'd8, 1, "lw wrap");
    run_op(4'b0011, 32'h0000_0100, 32'h0, 5'd9, 0, "bad load op");
    run_op(4'b1011, 32'h0000_0100, 32'h0, 5'd10, 0, "bad store op");
    run_op(4'b1001, 32'h0000_0202, 32'hBEEF, 5'd11, 2, "sh 202");

    // Reset while waiting for the RMW read response.
    @(negedge i_clk);
    check("rst ready", {31'h0, o_ready}, 32'h1);
    i_valid = 1'b1; i_op = 4'b1000; i_addr = 32'h400; i_wdata = 32'h55; i_rd = 5'd3;
    i_req_ready = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rst rmw req", {31'h0, o_req}, 32'h1);
    @(negedge i_clk);
    i_req_ready = 1'b0;
    check("rst in wait", {31'h0, o_req}, 32'h0);
    i_areset = 1'b1;
    #1;
    check("rst req low", {31'h0, o_req}, 32'h0);
    check("rst valid low", {31'h0, o_valid}, 32'h0);
    check("rst ready high", {31'h0, o_ready}, 32'h1);
    @(negedge i_clk);
    i_areset = 1'b0;
    mem[30'h40] = 32'h0BAD_F00D;
    run_op(4'b0010, 32'h0000_0100, 32'h0, 5'd12, 0, "lw after rst");

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? $urandom : (32'h1000 + $urandom_range(0, 63));
      run_op(4'($urandom_range(0, 15)), ra, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit in the memory-access stage, directly upstream of the data cache controller.
- Accepts one load/store per transaction from the execute pipeline.
- Checks alignment and formats byte/halfword/word loads with sign or zero extension.
- The cache only stores full 32-bit words, so sub-word stores are done as a read-modify-write (read word, merge lanes, write word).
- At most one cache request is outstanding at any time.

Parameters:
ADDR_SIZE, 32, byte-address width.
DATA_SIZE, 32, data word width; fixed at 32 (4 byte lanes).

Ports:
i_clk  in  1  system clock
i_areset  in  1  reset; one clock; reset is asynchronous and active-high
i_valid  in  1  pipeline presents an operation
o_ready  out  1  LSU idle and able to accept; transfer when i_valid && o_ready
i_addr  in  ADDR_SIZE  byte address
i_wdata  in  DATA_SIZE  store data, right-aligned
i_op  in  4  lsu_op_t: {store, funct3}
i_rd  in  5  destination register tag
o_valid  out  1  one-cycle completion pulse
o_rdata  out  DATA_SIZE  formatted load result; 0 for stores and faults
o_rd  out  5  tag of the completing operation
o_misaligned  out  1  qualifies o_valid; the access faulted
o_req  out  1  cache request
o_req_write  out  1  cache request is a store
o_addr  out  ADDR_SIZE  word-aligned address; bits [1:0] are always 0
o_store_data  out  DATA_SIZE  full word to write
i_req_ready  in  1  cache accepts a request; accept when o_req && i_req_ready
i_data_valid  in  1  cache response for the accepted request
i_data  in  DATA_SIZE  word currently held in cache

Behaviour:
- Reset: state IDLE; all outputs 0 except o_ready=1; operation registers cleared.
- Reset mid-operation: the in-flight request is abandoned with no o_valid. The cache controller has its own reset and flush.

State machine:
- IDLE
  - o_ready=1.
  - On transfer, latch addr/wdata/op/rd.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> FAULT.
  - Otherwise: SB/SH -> RMW_RD_REQ; all other ops -> REQ.
- REQ
  - o_req=1; o_req_write=store.
  - For SW, o_store_data=wdata.
  - Hold all request signals stable until accepted, then -> WAIT.
- WAIT
  - o_req must be 0. The cache reads a held request during its response cycle as a new one.
  - On i_data_valid: loads capture the formatted i_data; both loads and SW -> DONE.
- RMW_RD_REQ
  - o_req=1, o_req_write=0; on accept -> RMW_RD_WAIT.
- RMW_RD_WAIT
  - o_req=0.
  - On i_data_valid, register merged word -> RMW_WR_REQ:
    - SB replaces lane addr[1:0] with wdata[7:0].
    - SH replaces lane pair addr[1] with wdata[15:0].
- RMW_WR_REQ
  - o_req=1, o_req_write=1, o_store_data=merged word; on accept -> WAIT.
- DONE
  - o_valid=1 for one cycle, o_misaligned=0 -> IDLE.
- FAULT
  - o_valid=1, o_misaligned=1, o_rdata=0; no cache request -> IDLE.

Load formatting:
- Byte select addr[1:0]; halfword select addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- o_rdata is registered and held until the next o_valid.

Latency (cache responding one cycle after accept):
- Aligned load or SW: transfer cycle T -> o_req at T+1 -> i_data_valid at T+2 -> o_valid at T+3.
- SB/SH: o_valid at T+5.
- Fault: o_valid at T+1.

Boundary conditions:
- i_data_valid outside a WAIT state is ignored.
- i_req_ready low stretches the REQ states indefinitely.
- i_valid with o_ready=0 is not consumed; the pipeline holds it.
- Address wrap at 0xFFFF_FFFC is legal; no carry.
- Invalid i_op encodings (load funct3 3/6/7, store funct3 >= 3) are treated as misaligned faults.

Decomposition:
- multicore_pkg gains:
  - typedef enum lsu_op_t (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - LSU state enum.
  - Constant BYTE_LANES = DATA_SIZE/8.
- One combinational sub-module, mem_lsu_format:
  - Load extract/extend.
  - Store lane merge.
  - Misalignment check.
- mem_lsu holds the FSM and registers.

Test Plan:
- LW addr 0x100, cache returns 0xDEADBEEF: one o_req (write=0, addr 0x100); o_valid at T+3, o_rdata=0xDEADBEEF, o_rd echoed.
- LB addr 0x103, word 0x80FF1234: o_rdata=0xFFFFFF80. LBU same access: o_rdata=0x00000080. LHU addr 0x102: o_rdata=0x000080FF.
- SB addr 0x201, wdata 0xAA, old word 0x11223344: read request, then write request with o_store_data=0x1122AA44; o_valid at T+5.
- SW addr 0x300 with i_req_ready low for 4 cycles: o_req and payload held stable for all 4 cycles; exactly one accept; o_valid 2 cycles after accept.
- LW addr 0x102: no o_req; o_valid=1, o_misaligned=1 at T+1; o_ready returns next cycle.
- Reset asserted in RMW_RD_WAIT: o_req=0, o_valid=0, o_ready=1 immediately; the next LW completes normally.
